// File: rtl/write_axi4_interface_if.sv
// ----------------------------------------------------------------------------
// write_axi4_interface_if
//   Single-beat AXI4 write bundle (AW, W and B channels) between the FIFO
//   write engine and an AXI4 slave.
//
//   master : drives AW/W payload and valids, drives bready.
//   slave  : drives awready/wready, bvalid/bresp.
// ----------------------------------------------------------------------------
interface write_axi4_interface_if;
  logic        axi_awvalid;
  logic [31:0] axi_awaddr;
  logic        axi_awready;

  logic        axi_wvalid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wready;

  logic        axi_bvalid;
  logic [1:0]  axi_bresp;
  logic        axi_bready;

  modport master (
    output axi_awvalid, axi_awaddr,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bresp,
    output axi_bready
  );

  modport slave (
    input  axi_awvalid, axi_awaddr,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bresp,
    input  axi_bready
  );
endinterface

// File: rtl/write_axi4_interface.sv
// ----------------------------------------------------------------------------
// write_axi4_interface
//   Moves w_size_data bytes from a read-latency-1 FIFO to AXI4 memory starting
//   at waddr_reg, one 32-bit single-beat burst at a time (AW + W, then wait
//   for B). Sizes that are not a multiple of 4 round up to whole beats.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start_write   : begin a transfer (honoured only when idle)
//   w_size_data   : transfer length in bytes (0 = immediate done)
//   waddr_reg     : destination base byte address
//   write_done    : one-cycle pulse when the transfer finishes
//   write_err     : sticky, set by any non-OKAY write response
//   fifo_empty    : FIFO empty flag
//   ren           : FIFO read enable; data appears on fifo_rdata next cycle
//   fifo_rdata    : FIFO read data
//   axi           : AXI4 AW/W/B channels (master side)
// ----------------------------------------------------------------------------
module write_axi4_interface (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_write,
  input  logic [15:0]                   w_size_data,
  input  logic [31:0]                   waddr_reg,
  output logic                          write_done,
  output logic                          write_err,
  input  logic                          fifo_empty,
  output logic                          ren,
  input  logic [31:0]                   fifo_rdata,
  write_axi4_interface_if.master        axi
);

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_FETCH = 3'd1,
    W_LOAD  = 3'd2,
    W_XFER  = 3'd3,
    W_RESP  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [16:0] write_cnt;     // bytes completed; 17 bits so +4 past 65532 cannot wrap
  logic [16:0] cnt_plus4;
  logic        more_beats;
  logic        aw_pend_nxt;   // AW still outstanding after this edge
  logic        w_pend_nxt;    // W still outstanding after this edge
  logic        b_fire;

  assign cnt_plus4   = write_cnt + 17'd4;
  assign more_beats  = cnt_plus4 < {1'b0, w_size_data};
  assign aw_pend_nxt = axi.axi_awvalid & ~axi.axi_awready;
  assign w_pend_nxt  = axi.axi_wvalid & ~axi.axi_wready;
  assign b_fire      = axi.axi_bvalid & axi.axi_bready;

  // Every beat is a complete single-beat burst, so strobe and last simply
  // follow the data valid.
  assign axi.axi_wstrb = {4{axi.axi_wvalid}};
  assign axi.axi_wlast = axi.axi_wvalid;

  // NOTE: state and every register below update with non-blocking assignments
  // so all flops sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= W_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    case (state)
      W_IDLE:  if (start_write && (w_size_data != 16'd0)) state_nxt = W_FETCH;
      W_FETCH: begin
        // ren is gated by !fifo_empty combinationally, so it can never fire
        // on an empty FIFO and only one word is ever in flight.
        if (!fifo_empty) begin
          ren       = 1'b1;
          state_nxt = W_LOAD;
        end
      end
      W_LOAD:  state_nxt = W_XFER;
      W_XFER:  if (!aw_pend_nxt && !w_pend_nxt) state_nxt = W_RESP;
      W_RESP:  if (b_fire) state_nxt = more_beats ? W_FETCH : W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because every output must
  // read zero straight after reset, even when it strikes mid-transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_cnt       <= '0;
      write_done      <= 1'b0;
      write_err       <= 1'b0;
      axi.axi_awvalid <= 1'b0;
      axi.axi_awaddr  <= '0;
      axi.axi_wvalid  <= 1'b0;
      axi.axi_wdata   <= '0;
      axi.axi_bready  <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (state)
        W_IDLE: begin
          write_cnt <= '0;
          if (start_write) begin
            if (w_size_data == 16'd0) write_done <= 1'b1;
            else                      write_err  <= 1'b0;
          end
        end
        W_LOAD: begin
          axi.axi_wdata   <= fifo_rdata;
          axi.axi_awaddr  <= waddr_reg + {15'd0, write_cnt};
          axi.axi_awvalid <= 1'b1;
          axi.axi_wvalid  <= 1'b1;
        end
        W_XFER: begin
          // AW and W retire independently; B is opened once both are gone.
          if (!aw_pend_nxt) axi.axi_awvalid <= 1'b0;
          if (!w_pend_nxt)  axi.axi_wvalid  <= 1'b0;
          if (!aw_pend_nxt && !w_pend_nxt) axi.axi_bready <= 1'b1;
        end
        W_RESP: begin
          if (b_fire) begin
            axi.axi_bready <= 1'b0;
            write_cnt      <= cnt_plus4;
            if (axi.axi_bresp != 2'b00) write_err <= 1'b1;
            if (!more_beats)            write_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/write_axi4_interface.md
WRITE_AXI4_INTERFACE -- requirements
Module: write_axi4_interface

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start_write  input  1  controller pulse; starts a transfer when idle.
REQ-004 SHALL have port w_size_data  input  16  byte count of the transfer.
REQ-005 SHALL have port waddr_reg  input  32  destination base byte address.
REQ-006 SHALL have port write_done  output  1  one-cycle pulse at transfer end.
REQ-007 SHALL have port write_err  output  1  sticky flag, set when any beat returns non-OKAY response.
REQ-008 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port ren  output  1  FIFO read enable; FIFO data is valid on fifo_rdata the cycle after ren.
REQ-010 SHALL have port fifo_rdata  input  32  FIFO read data.
REQ-011 SHALL have ports axi_awvalid out 1, axi_awaddr out 32, axi_awready in 1  AXI4 AW channel.
REQ-012 SHALL have ports axi_wvalid out 1, axi_wdata out 32, axi_wstrb out 4, axi_wlast out 1, axi_wready in 1  AXI4 W channel.
REQ-013 SHALL have ports axi_bvalid in 1, axi_bresp in 2, axi_bready out 1  AXI4 B channel.

Function
REQ-014 SHALL implement FSM states W_IDLE, W_FETCH, W_LOAD, W_XFER, W_RESP; unused encodings go to W_IDLE.
REQ-015 SHALL use a 17-bit byte counter write_cnt, cleared in W_IDLE, incremented by 4 per completed beat.
REQ-016 W_IDLE: on start_write with w_size_data!=0 SHALL clear write_err and go to W_FETCH; with w_size_data==0 SHALL pulse write_done next cycle, no AXI or FIFO activity.
REQ-017 W_FETCH: while fifo_empty SHALL wait with ren=0; when !fifo_empty SHALL assert ren for exactly one cycle and go to W_LOAD.
REQ-018 W_LOAD: SHALL register fifo_rdata into axi_wdata, set axi_awaddr = waddr_reg + write_cnt (32-bit, wraps modulo 2^32), assert axi_awvalid and axi_wvalid, go to W_XFER.
REQ-019 axi_wstrb SHALL be 4'hF and axi_wlast SHALL be 1 whenever axi_wvalid=1; both 0 otherwise.
REQ-020 W_XFER: axi_awvalid SHALL drop the cycle after awvalid&&awready, axi_wvalid the cycle after wvalid&&wready, independently; handshakes in either order or the same cycle SHALL be accepted.
REQ-021 axi_awaddr and axi_wdata SHALL stay stable while their valid is high; a valid SHALL never drop before its handshake.
REQ-022 When both handshakes are complete, SHALL go to W_RESP with axi_bready=1.
REQ-023 W_RESP: on bvalid&&bready SHALL drop axi_bready, set write_err if axi_bresp!=2'b00, add 4 to write_cnt.
REQ-024 After REQ-023, if write_cnt+4 < w_size_data SHALL return to W_FETCH; else SHALL pulse write_done and go to W_IDLE. A non-multiple-of-4 size rounds up to whole beats.
REQ-025 start_write outside W_IDLE SHALL be ignored; waddr_reg and w_size_data SHALL be treated as stable for the whole transfer.
REQ-026 ren SHALL never be asserted while fifo_empty=1; at most one FIFO word SHALL be outstanding.
REQ-027 A beat with non-OKAY response SHALL NOT be retried; transfer continues.

Reset
REQ-028 On rst=1 at a clock edge, SHALL force W_IDLE, write_cnt=0, and all outputs (write_done, write_err, ren, axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready) to 0, including mid-transfer; no further handshake completion is owed after reset.

Verification
REQ-029 size=16, base=0x1000, FIFO pre-filled 4 words, ready signals always 1, OKAY -> AW addresses 0x1000,0x1004,0x1008,0x100C in order, data matches FIFO order, one write_done pulse, write_err=0.
REQ-030 size=8, FIFO empty 10 cycles then one word per 5 cycles -> ren never high while empty, exactly 2 ren pulses, 2 beats.
REQ-031 awready delayed 3 cycles, wready immediate (and reversed case) -> valids held with stable addr/data until own handshake, single B handshake per beat.
REQ-032 size=12, second beat bresp=2'b10 -> write_err=1 from that cycle, third beat still issued, write_done pulses, write_err cleared on next start_write.
REQ-033 size=0 -> write_done one cycle after start, no ren/awvalid/wvalid; size=5 -> 2 beats.
REQ-034 rst=1 asserted while axi_wvalid=1 in W_XFER -> next cycle all outputs 0, FSM idle; new start_write runs normally from write_cnt=0.
